systolic_array_nxn: RTL

Parametrised N x N output-stationary systolic matrix-multiply engine for the combined datapath. It computes C = A x B for an N x K by K x N job, where K is set by the stream length. Input skewing is done internally, so the caller presents one unskewed A column and B row per beat. A small controller handles the valid/ready handshake, per-job accumulator clear, pipeline drain and a result-valid pulse.

---
 rtl/systolic_array_nxn.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic matrix multiply. Unskewed A columns and B rows are skewed
// internally, each PE accumulates its C[i][j] in place, and c_valid pulses once a job has drained.
//
// state | meaning
// IDLE  | no job open; the next accepted beat starts a new job (first tag)
// LOAD  | job open; beats accepted, bubbles allowed
// DRAIN | last beat accepted; counting down until it reaches PE(N-1,N-1)
module systolic_array_nxn #(
    parameter int N      = 3,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [N*DATA_W-1:0]  a_vec,
    input  logic [N*DATA_W-1:0]  b_vec,
    output logic [N*N*ACC_W-1:0] c_flat,
    output logic                 c_valid,
    output logic                 busy
);
    localparam int PW = (2*DATA_W > ACC_W) ? 2*DATA_W : ACC_W;
    localparam int CW = $clog2(2*N);
    localparam int TW = DATA_W + 2;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(2*N-2);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] drain_cnt, drain_cnt_d;
    logic          c_valid_d;
    logic          accept, first;

    assign in_ready = (state_q != DRAIN);
    assign accept   = in_valid & in_ready;
    assign first    = accept & (state_q == IDLE);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drain_cnt <= '0;
            c_valid   <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_cnt <= drain_cnt_d;
            c_valid   <= c_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt;
        c_valid_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept && in_last) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d   = IDLE;
                    c_valid_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Input skew: lane i is delayed i cycles; the A lane also carries the valid/first tags.
    logic [N*DATA_W-1:0] ska, skb;
    logic [N-1:0]        skv, skf;

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign ska[DATA_W-1:0] = a_vec[DATA_W-1:0];
            assign skb[DATA_W-1:0] = b_vec[DATA_W-1:0];
            assign skv[0]          = accept;
            assign skf[0]          = first;
        end else begin : g_dly
            logic [TW-1:0]     sa [i];
            logic [DATA_W-1:0] sb [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        sa[k] <= '0;
                        sb[k] <= '0;
                    end
                end else begin
                    sa[0] <= {first, accept, a_vec[i*DATA_W +: DATA_W]};
                    sb[0] <= b_vec[i*DATA_W +: DATA_W];
                    for (int k = 1; k < i; k++) begin
                        sa[k] <= sa[k-1];
                        sb[k] <= sb[k-1];
                    end
                end
            end
            assign ska[i*DATA_W +: DATA_W] = sa[i-1][DATA_W-1:0];
            assign skv[i]                  = sa[i-1][DATA_W];
            assign skf[i]                  = sa[i-1][DATA_W+1];
            assign skb[i*DATA_W +: DATA_W] = sb[i-1];
        end
    end

    function automatic logic [ACC_W-1:0] mul(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
        logic [PW-1:0] xe, ye;
        if (SIGNED != 0) begin
            xe = {{(PW-DATA_W){x[DATA_W-1]}}, x};
            ye = {{(PW-DATA_W){y[DATA_W-1]}}, y};
        end else begin
            xe = {{(PW-DATA_W){1'b0}}, x};
            ye = {{(PW-DATA_W){1'b0}}, y};
        end
        return ACC_W'(xe * ye);
    endfunction

    // pa[i]/pv[i]/pf[i] slice j and pb[j] slice i are what PE(i,j) sees this cycle;
    // ah/bh hold the values each PE forwards right/down (the outer edge needs no register).
    logic [N*DATA_W-1:0]     pa [N];
    logic [N*DATA_W-1:0]     pb [N];
    logic [N-1:0]            pv [N];
    logic [N-1:0]            pf [N];
    logic [(N-1)*DATA_W-1:0] ah [N];
    logic [(N-1)*DATA_W-1:0] bh [N];
    logic [N-2:0]            avh [N];
    logic [N-2:0]            afh [N];
    logic [ACC_W-1:0]        prod [N*N];
    logic [N*N*ACC_W-1:0]    acc;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pa[i] = {ah[i], ska[i*DATA_W +: DATA_W]};
            pb[i] = {bh[i], skb[i*DATA_W +: DATA_W]};
            pv[i] = {avh[i], skv[i]};
            pf[i] = {afh[i], skf[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i*N+j] = mul(pa[i][j*DATA_W +: DATA_W], pb[j][i*DATA_W +: DATA_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            for (int i = 0; i < N; i++) begin
                ah[i]  <= '0;
                bh[i]  <= '0;
                avh[i] <= '0;
                afh[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                ah[i]  <= pa[i][(N-1)*DATA_W-1:0];
                bh[i]  <= pb[i][(N-1)*DATA_W-1:0];
                avh[i] <= pv[i][N-2:0];
                afh[i] <= pf[i][N-2:0];
                for (int j = 0; j < N; j++) begin
                    if (pv[i][j]) begin
                        acc[(i*N+j)*ACC_W +: ACC_W] <= pf[i][j] ? prod[i*N+j]
                            : acc[(i*N+j)*ACC_W +: ACC_W] + prod[i*N+j];
                    end
                end
            end
        end
    end

    assign c_flat = acc;

endmodule
